// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS main control state machine
module multicycle_control_fsm #(
    parameter int RESET_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       brk,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       aluout_write,
    output logic [1:0] pc_source,
    output logic       halted,
    output logic       illegal_op,
    output logic [4:0] state_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES - 1);

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_R_EXEC     = 5'd4,
        S_R_WB       = 5'd5,
        S_ADDI_EXEC  = 5'd6,
        S_ADDI_WB    = 5'd7,
        S_MEM_ADDR   = 5'd8,
        S_LW_READ    = 5'd9,
        S_LW_WAIT    = 5'd10,
        S_LW_WB      = 5'd11,
        S_SW_WRITE   = 5'd12,
        S_BRANCH     = 5'd13,
        S_JUMP       = 5'd14,
        S_HALT       = 5'd15,
        S_ILLEGAL    = 5'd16
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] rst_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RESET;
            rst_cnt <= RST_LOAD;
        end else begin
            state <= next_state;
            if (state == S_RESET && rst_cnt != 4'd0)
                rst_cnt <= rst_cnt - 4'd1;
        end
    end

    assign state_dbg = state;

    always_comb begin
        next_state   = state;
        pc_write     = 1'b0;
        iord         = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 3'b000;
        aluout_write = 1'b0;
        pc_source    = 2'b00;
        halted       = 1'b0;
        illegal_op   = 1'b0;

        case (state)
            S_RESET: begin
                if (rst_cnt == 4'd0)
                    next_state = S_FETCH;
            end
            S_FETCH: begin
                next_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b01;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // branch target is computed here while the opcode is being decoded
                alu_src_b    = 2'b11;
                aluout_write = 1'b1;
                case (opcode)
                    OP_RTYPE:       next_state = S_R_EXEC;
                    OP_ADDI:        next_state = S_ADDI_EXEC;
                    OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    default:        next_state = S_ILLEGAL;
                endcase
            end
            S_R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_op       = 3'b010;
                aluout_write = ~brk;
                next_state   = brk ? S_HALT : S_R_WB;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                aluout_write = 1'b1;
                next_state   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                aluout_write = 1'b1;
                if (opcode == OP_LW)
                    next_state = S_LW_READ;
                else if (opcode == OP_SW)
                    next_state = S_SW_WRITE;
                else
                    next_state = S_ILLEGAL;
            end
            S_LW_READ: begin
                iord       = 1'b1;
                next_state = S_LW_WAIT;
            end
            S_LW_WAIT: begin
                iord       = 1'b1;
                mdr_write  = 1'b1;
                next_state = S_LW_WB;
            end
            S_LW_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_SW_WRITE: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b001;
                pc_source  = 2'b01;
                pc_write   = (opcode == OP_BEQ) ? zero : ~zero;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                next_state = S_ILLEGAL;
            end
            default: begin
                next_state = S_ILLEGAL;
            end
        endcase
    end

endmodule
